imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Writer side of instruction-memory port: accepts byte stream (valid/ready), packs big-endian
//  32-bit words, drives instruction memory write_enabled/input_address/input_data.
//  Holds CPU in reset (cpu_reset) until program fully loaded; sits between host link and cpu.
// PARAMETERS
//  BASE_ADDR   32'h0000_0000  byte address of first word written (word aligned)
//  MAX_WORDS   256            largest accepted program length, words
//  CNT_WIDTH   16             width of word counter / header length field used
// PORTS
//  clock            in   1   system clock
//  reset            in   1   synchronous, active-high
//  start            in   1   pulse: begin load session
//  byte_valid       in   1   byte_data valid
//  byte_data        in   8   stream byte
//  byte_ready       out  1   loader accepts byte this cycle (valid&ready = transfer)
//  imem_write_en    out  1   to memory write_enabled; one-cycle pulse per word
//  imem_address     out  32  to memory input_address (byte address)
//  imem_data        out  32  to memory input_data
//  cpu_reset        out  1   high while not DONE; drives cpu reset
//  busy             out  1   session in progress
//  done             out  1   level: program loaded, cpu released
//  err_overflow     out  1   sticky: header length > MAX_WORDS
//  err_checksum     out  1   sticky: trailer mismatch (0 when feature compiled out)
// BEHAVIOUR
//  Reset: state IDLE; byte_ready=0, imem_write_en=0, imem_address=BASE_ADDR, imem_data=0,
//   cpu_reset=1, busy=0, done=0, errors=0, counters/assembler cleared. Reset mid-session aborts.
//  Stream: 4-byte header = word count N (low CNT_WIDTH bits used, upper must be 0 else overflow),
//   then N words, MSB byte first. Optional 4-byte checksum trailer (see CONFIGURATION).
//  States: IDLE -start-> HEADER -4 bytes-> DATA (N>0) | CHECK/DONE (N=0)
//   DATA -4th byte-> WRITE (1 cycle) -> DATA (more words) | CHECK/DONE (last word)
//   HEADER with N>MAX_WORDS -> ERROR. CHECK -> DONE (match) | ERROR (mismatch).
//   DONE/ERROR -start-> HEADER (new session; cpu_reset reasserted same edge).
//  byte_ready=1 only in HEADER, DATA, CHECK; 0 in IDLE, WRITE, DONE, ERROR.
//  start ignored while busy. byte_valid outside ready states ignored (not consumed).
//  Word k: imem_address = BASE_ADDR + 4*k (mod 2^32 wrap), imem_data = packed word,
//   imem_write_en high exactly one cycle (WRITE), cycle after 4th byte transfer.
//  cpu_reset deasserts the cycle DONE is entered; done=1 and busy=0 same cycle.
//  ERROR: cpu_reset stays 1, done=0, busy=0, error flag sticky until start or reset.
//  Errors cleared on start.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined: after last word (or header if N=0) CHECK state consumes 4-byte
//   trailer; compare to 32-bit mod-2^32 sum of all data words; mismatch -> err_checksum, ERROR.
//  Undefined: no CHECK state, no trailer; last WRITE/N=0 header goes directly to DONE;
//   err_checksum tied 0.
// STRUCTURE
//  loader_pkg: state enum (IDLE,HEADER,DATA,WRITE,CHECK,DONE,ERROR), BYTES_PER_WORD=4.
//  Sub-module byte_assembler: 2-bit byte index, 32-bit shift register, word_valid pulse on 4th byte;
//   cleared on reset and on session start.
// TESTING
//  N=2 words 0x2008_0005,0x0000_0000 -> writes @0x0,0x4 data as sent; done=1, cpu_reset=0.
//  N=0 header -> no imem_write_en pulse; DONE (or CHECK with trailer 0 when enabled).
//  N=MAX_WORDS+1 -> err_overflow=1, ERROR, cpu_reset=1, no writes.
//  byte_valid gaps/random stalls + start during DATA -> identical writes, start ignored.
//  reset asserted after 2 bytes of word 1 -> IDLE, next session writes word 0 at BASE_ADDR.
//  EN: trailer 0x2008_0005 for above program -> DONE; trailer 0x0 -> err_checksum=1, ERROR.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory loader.
// States, word geometry and the byte-acceptance decode.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_e;

  localparam int BYTES_PER_WORD = 4;

  function automatic logic accepts(state_e s);
    return (s == S_HEADER) || (s == S_DATA) || (s == S_CHECK);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream link between host and loader.
// valid/ready: a byte moves on a clock where both are high.
interface imem_loader_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready
  );
endinterface

// File: rtl/imem_loader_byte_assembler.sv
// Packs four stream bytes MSB-first into a word.
// word_valid_o pulses in the cycle the fourth byte is taken.
module byte_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [1:0]  idx_q;
  logic [31:0] shift_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      idx_q   <= '0;
      shift_q <= '0;
    end else if (en_i) begin
      idx_q   <= idx_q + 2'd1;
      shift_q <= {shift_q[23:0], byte_i};
    end
  end

  assign word_o       = {shift_q[23:0], byte_i};
  assign word_valid_o = en_i &&
    (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed word stream into imem, holding the cpu in reset.
// Define LOADER_CHECKSUM_EN to require a 32-bit sum trailer.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256,
  parameter int          CNT_WIDTH = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  imem_loader_if.slave bs,
  output logic         imem_write_en,
  output logic [31:0]  imem_address,
  output logic [31:0]  imem_data,
  output logic         cpu_reset,
  output logic         busy,
  output logic         done,
  output logic         err_overflow,
  output logic         err_checksum
);

`ifdef LOADER_CHECKSUM_EN
  localparam state_e TAIL = S_CHECK;
`else
  localparam state_e TAIL = S_DONE;
`endif
  localparam logic TAIL_DONE = (TAIL == S_DONE);

  state_e               state_q;
  logic [CNT_WIDTH-1:0] cnt_q, len_q;
  logic                 we_q, cpurst_q;
  logic                 busy_q, done_q, ovf_q;
  logic [31:0]          addr_q, data_q;

  logic                 fire, take_start;
  logic                 word_valid;
  logic [31:0]          word;
  logic [CNT_WIDTH-1:0] hdr_len, cnt_nx;
  logic                 hdr_ovf;

  assign bs.byte_ready = accepts(state_q);
  assign fire          = bs.byte_valid && bs.byte_ready;
  assign take_start    = start && (state_q == S_IDLE ||
    state_q == S_DONE || state_q == S_ERROR);

  byte_assembler u_asm (
    .clk          (clock),
    .rst          (reset),
    .clr_i        (take_start),
    .en_i         (fire),
    .byte_i       (bs.byte_data),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  assign hdr_len = word[CNT_WIDTH-1:0];
  assign hdr_ovf = ((word >> CNT_WIDTH) != 32'd0) ||
    (32'(hdr_len) > 32'(MAX_WORDS));
  assign cnt_nx  = cnt_q + CNT_WIDTH'(1);

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] sum_q;
  logic        cks_q;
  logic        cks_ok;

  assign cks_ok = (word == sum_q);

  always_ff @(posedge clock) begin
    if (reset || take_start) begin
      sum_q <= '0;
      cks_q <= 1'b0;
    end else if (state_q == S_DATA && word_valid) begin
      sum_q <= sum_q + word;
    end else if (state_q == S_CHECK && word_valid && !cks_ok) begin
      cks_q <= 1'b1;
    end
  end

  assign err_checksum = cks_q;
`else
  assign err_checksum = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= BASE_ADDR;
      data_q   <= '0;
      cpurst_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE, S_ERROR: if (start) begin
          state_q  <= S_HEADER;
          cnt_q    <= '0;
          addr_q   <= BASE_ADDR;
          cpurst_q <= 1'b1;
          busy_q   <= 1'b1;
          done_q   <= 1'b0;
          ovf_q    <= 1'b0;
        end
        S_HEADER: if (word_valid) begin
          len_q <= hdr_len;
          if (hdr_ovf) begin
            state_q <= S_ERROR;
            ovf_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else if (hdr_len == '0) begin
            state_q  <= TAIL;
            busy_q   <= !TAIL_DONE;
            done_q   <= TAIL_DONE;
            cpurst_q <= !TAIL_DONE;
          end else begin
            state_q <= S_DATA;
          end
        end
        S_DATA: if (word_valid) begin
          state_q <= S_WRITE;
          we_q    <= 1'b1;
          data_q  <= word;
          addr_q  <= BASE_ADDR + {30'(cnt_q), 2'b00};
        end
        S_WRITE: begin
          cnt_q <= cnt_nx;
          if (cnt_nx == len_q) begin
            state_q  <= TAIL;
            busy_q   <= !TAIL_DONE;
            done_q   <= TAIL_DONE;
            cpurst_q <= !TAIL_DONE;
          end else begin
            state_q <= S_DATA;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: if (word_valid) begin
          busy_q <= 1'b0;
          if (cks_ok) begin
            state_q  <= S_DONE;
            done_q   <= 1'b1;
            cpurst_q <= 1'b0;
          end else begin
            state_q <= S_ERROR;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign imem_write_en = we_q;
  assign imem_address  = addr_q;
  assign imem_data     = data_q;
  assign cpu_reset     = cpurst_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_overflow  = ovf_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued as words are sent.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        imem_write_en;
  logic [31:0] imem_address, imem_data;
  logic        cpu_reset, busy, done;
  logic        err_overflow, err_checksum;

  imem_loader_if bs ();

  imem_loader dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .bs            (bs.slave),
    .imem_write_en (imem_write_en),
    .imem_address  (imem_address),
    .imem_data     (imem_data),
    .cpu_reset     (cpu_reset),
    .busy          (busy),
    .done          (done),
    .err_overflow  (err_overflow),
    .err_checksum  (err_checksum)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int nwr   = 0;
  logic [63:0] sbq[$];

  always @(negedge clock) begin
    if (!reset && imem_write_en) begin
      logic [63:0] exp;
      nwr++;
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL write_unexpected got=%h/%h req=none",
                 imem_address, imem_data);
      end else begin
        exp = sbq.pop_front();
        if ({imem_address, imem_data} !== exp) begin
          bad++;
          $display("FAIL write got=%h/%h req=%h/%h",
                   imem_address, imem_data, exp[63:32], exp[31:0]);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n = 0;
    if (gaps) idle($urandom_range(0, 2));
    bs.byte_valid = 1'b1;
    bs.byte_data  = b;
    forever begin
      @(negedge clock);
      if (bs.byte_ready) break;
      n++;
      if (n > 100) begin
        total++; bad++;
        $display("FAIL byte_timeout got=ready0 req=ready1");
        break;
      end
    end
    @(posedge clock); #1;
    bs.byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], gaps);
  endtask

  // Full session: header, words (queueing expected writes), optional trailer
  task automatic session(input logic [31:0] words[$],
                         input bit gaps, input bit poke,
                         input logic [31:0] trailer, input bit use_sum);
    logic [31:0] sum = 32'd0;
    pulse_start();
    send_word(32'(words.size()), gaps);
    foreach (words[k]) begin
      sbq.push_back({BASE + 32'(4 * k), words[k]});
      sum += words[k];
      if (poke && k == 1) begin
        send_byte(words[k][31:24], gaps);
        send_byte(words[k][23:16], gaps);
        pulse_start();
        total++;
        if (busy !== 1'b1 || cpu_reset !== 1'b1) begin
          bad++;
          $display("FAIL start_ignored got=%b%b req=11", busy, cpu_reset);
        end
        send_byte(words[k][15:8], gaps);
        send_byte(words[k][7:0], gaps);
      end else begin
        send_word(words[k], gaps);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_word(use_sum ? sum : trailer, gaps);
`else
    if (use_sum && trailer != 32'd0) sum = trailer;
`endif
  endtask

  task automatic wait_settle();
    int n = 0;
    while (busy === 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL settle_timeout got=%b req=0", busy);
    end
    @(negedge clock);
  endtask

  task automatic check_end(input string nm, input logic d, input logic cr,
                           input logic ov, input logic ck, input int wr);
    total++;
    if ({done, cpu_reset, err_overflow, err_checksum, busy} !==
        {d, cr, ov, ck, 1'b0}) begin
      bad++;
      $display("FAIL %s flags got=%b%b%b%b%b req=%b%b%b%b0", nm,
               done, cpu_reset, err_overflow, err_checksum, busy,
               d, cr, ov, ck);
    end
    total++;
    if (nwr !== wr || sbq.size() != 0) begin
      bad++;
      $display("FAIL %s writes got=%0d left=%0d req=%0d left=0",
               nm, nwr, sbq.size(), wr);
    end
  endtask

  task automatic test_reset();
    bs.byte_valid = 1'b0;
    bs.byte_data  = 8'h00;
    idle(3);
    @(negedge clock);
    total++;
    if ({bs.byte_ready, imem_write_en, busy, done,
         err_overflow, err_checksum} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctl got=%b%b%b%b%b%b req=000000", bs.byte_ready,
               imem_write_en, busy, done, err_overflow, err_checksum);
    end
    total++;
    if (imem_address !== BASE || imem_data !== 32'd0 || cpu_reset !== 1'b1) begin
      bad++;
      $display("FAIL reset_bus got=%h/%h/%b req=%h/0/1",
               imem_address, imem_data, cpu_reset, BASE);
    end
    #1 reset = 1'b0;
    idle(2);
  endtask

  task automatic test_two_words();
    logic [31:0] w[$] = '{32'h2008_0005, 32'h0000_0000};
    int w0 = nwr;
    session(w, 1'b0, 1'b0, 32'd0, 1'b1);
    wait_settle();
    check_end("two_words", 1'b1, 1'b0, 1'b0, 1'b0, w0 + 2);
  endtask

  task automatic test_back_to_back();
    pulse_start();
    total++;
    if ({busy, done, cpu_reset} !== 3'b101) begin
      bad++;
      $display("FAIL restart got=%b%b%b req=101", busy, done, cpu_reset);
    end
    send_word(32'd0, 1'b0);
  endtask

  task automatic test_zero();
    int w0 = nwr;
    test_back_to_back();
`ifdef LOADER_CHECKSUM_EN
    send_word(32'd0, 1'b0);
`endif
    wait_settle();
    check_end("zero", 1'b1, 1'b0, 1'b0, 1'b0, w0);
  endtask

  task automatic test_overflow();
    int w0 = nwr;
    pulse_start();
    send_word(32'd257, 1'b0);
    wait_settle();
    check_end("ovf_len", 1'b0, 1'b1, 1'b1, 1'b0, w0);
    pulse_start();
    total++;
    if (err_overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clear got=%b req=0", err_overflow);
    end
    send_word(32'h0001_0001, 1'b0);
    wait_settle();
    check_end("ovf_upper", 1'b0, 1'b1, 1'b1, 1'b0, w0);
  endtask

  task automatic test_stalls();
    logic [31:0] w[$];
    int w0 = nwr;
    for (int i = 0; i < 6; i++) w.push_back($urandom());
    session(w, 1'b1, 1'b1, 32'd0, 1'b1);
    wait_settle();
    check_end("stalls", 1'b1, 1'b0, 1'b0, 1'b0, w0 + 6);
  endtask

  task automatic test_abort();
    logic [31:0] w[$] = '{32'hCAFE_BABE};
    int w0 = nwr;
    pulse_start();
    send_word(32'd2, 1'b0);
    sbq.push_back({BASE, 32'h1111_2222});
    send_word(32'h1111_2222, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    @(negedge clock);
    check_end("abort", 1'b0, 1'b1, 1'b0, 1'b0, w0 + 1);
    total++;
    if (imem_address !== BASE || bs.byte_ready !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle got=%h/%b req=%h/0",
               imem_address, bs.byte_ready, BASE);
    end
    session(w, 1'b0, 1'b0, 32'd0, 1'b1);
    wait_settle();
    check_end("after_abort", 1'b1, 1'b0, 1'b0, 1'b0, w0 + 2);
  endtask

  task automatic test_checksum();
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] w[$] = '{32'h2008_0005, 32'h0000_0000};
    int w0 = nwr;
    session(w, 1'b0, 1'b0, 32'h0000_0000, 1'b0);
    wait_settle();
    check_end("cks_bad", 1'b0, 1'b1, 1'b0, 1'b1, w0 + 2);
    session(w, 1'b0, 1'b0, 32'h2008_0005, 1'b0);
    wait_settle();
    check_end("cks_good", 1'b1, 1'b0, 1'b0, 1'b0, w0 + 4);
`endif
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_zero();
    test_overflow();
    test_stalls();
    test_abort();
    test_checksum();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
